// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bundle between the MEM stage and data_mem_ctrl
//
// Signals:
//   result      byte address (ALU result)
//   mem_wr      store request
//   mem_rd      load request
//   funct3      RV32I access size / extension select
//   rdb         store data
//   read_data   extended load result, meaningful while rd_valid = 1
//   rd_valid    one-cycle load-result pulse
//   fault       one-cycle pulse after a rejected request
//   fault_cause 00 none, 01 misaligned, 10 out of range, 11 illegal funct3
// Modports: master drives requests (core / bench), slave is the memory controller.

interface data_mem_ctrl_if;
    logic [31:0] result;
    logic        mem_wr;
    logic        mem_rd;
    logic [2:0]  funct3;
    logic [31:0] rdb;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        output result, mem_wr, mem_rd, funct3, rdb,
        input  read_data, rd_valid, fault, fault_cause
    );

    modport slave (
        input  result, mem_wr, mem_rd, funct3, rdb,
        output read_data, rd_valid, fault, fault_cause
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32 MEM-stage data memory with byte/half/word access and pipelined reads
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two, >= 4)
//   READ_LATENCY  edges from accepted load to rd_valid (1..4)
// Ports:
//   clock  single rising-edge clock
//   reset  synchronous active-low reset
//   bus    data_mem_ctrl_if.slave: request inputs, load result and fault outputs

module data_mem_ctrl #(
    parameter int DEPTH_WORDS  = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    data_mem_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Array has no reset; contents are undefined until written.
    logic [31:0] mem_array [DEPTH_WORDS];

    logic          req;
    logic          illegal;
    logic          misaligned;
    logic          out_of_range;
    logic          reject;
    logic          accept_wr;
    logic          accept_rd;
    logic [1:0]    new_cause;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   byte_word;
    logic [31:0]   half_word;
    logic [31:0]   load_ext;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];
    logic                    fault_q, fault_d;
    logic [1:0]              cause_q, cause_d;

    assign req          = bus.mem_wr | bus.mem_rd;
    assign word_idx     = bus.result[AW+1:2];
    assign lane         = bus.result[1:0];
    assign out_of_range = |bus.result[31:AW+2];

    // A simultaneous load is dropped, so legality is judged as a store whenever mem_wr is set.
    always_comb begin
        illegal = 1'b0;
        if (bus.mem_wr) begin
            illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

    // funct3[1:0] encodes the access size for every legal code (00 byte, 01 half, 10 word).
    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'b01:   misaligned = bus.result[0];
            2'b10:   misaligned = |bus.result[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        new_cause = 2'b00;
        if (illegal)         new_cause = 2'b11;
        else if (misaligned) new_cause = 2'b01;
        else if (out_of_range) new_cause = 2'b10;
    end

    assign reject    = req & (illegal | misaligned | out_of_range);
    assign accept_wr = bus.mem_wr & ~reject;
    assign accept_rd = bus.mem_rd & ~bus.mem_wr & ~reject;

    // Load path: read the current word and align the selected lane(s) to bit 0.
    assign rd_word   = mem_array[word_idx];
    assign byte_word = rd_word >> {lane, 3'b000};
    assign half_word = rd_word >> {lane[1], 4'b0000};

    always_comb begin
        load_ext = rd_word;
        case (bus.funct3)
            3'b000:  load_ext = {{24{byte_word[7]}}, byte_word[7:0]};
            3'b001:  load_ext = {{16{half_word[15]}}, half_word[15:0]};
            3'b100:  load_ext = {24'h0, byte_word[7:0]};
            3'b101:  load_ext = {16'h0, half_word[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    // Store path: replicate the narrow data into every lane and gate with byte enables.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = bus.rdb;
        case (bus.funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{bus.rdb[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.rdb[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = bus.rdb;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset && accept_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_array[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read pipeline: each stage's data only moves when its source stage is valid,
    // so the last stage (read_data) holds its value between pulses.
    always_comb begin
        vld_d[0] = accept_rd;
        dat_d[0] = accept_rd ? load_ext : dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    assign fault_d = reject;
    assign cause_d = reject ? new_cause : cause_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= 32'h0;
        end else begin
            vld_q   <= vld_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
        end
    end

    assign bus.rd_valid    = vld_q[READ_LATENCY-1];
    assign bus.read_data   = dat_q[READ_LATENCY-1];
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl at READ_LATENCY 1 and 3

module tb_data_mem_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if if1();
    data_mem_ctrl_if if3();

    data_mem_ctrl #(.DEPTH_WORDS(128), .READ_LATENCY(1)) u_l1 (.clock(clk), .reset(rst_n), .bus(if1.slave));
    data_mem_ctrl #(.DEPTH_WORDS(128), .READ_LATENCY(3)) u_l3 (.clock(clk), .reset(rst_n), .bus(if3.slave));

    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    exp_t q1r[$];
    exp_t q1f[$];
    exp_t q3r[$];
    exp_t q3f[$];

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;
    localparam int K_NONE = 0, K_READ = 1, K_FAULT = 2;

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        if1.mem_wr = wr; if1.mem_rd = rd; if1.funct3 = f3; if1.result = addr; if1.rdb = data;
        if3.mem_wr = wr; if3.mem_rd = rd; if3.funct3 = f3; if3.result = addr; if3.rdb = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Present one request for one cycle and queue its expected response.
    task automatic issue(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int kind, input logic [31:0] expv, input bit to3);
        drive(wr, rd, f3, addr, data);
        if (kind == K_READ) begin
            q1r.push_back('{expv, cyc + 1});
            if (to3) q3r.push_back('{expv, cyc + 3});
        end else if (kind == K_FAULT) begin
            q1f.push_back('{expv, cyc + 1});
            if (to3) q3f.push_back('{expv, cyc + 1});
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        issue(1'b1, 1'b0, f3, addr, data, K_NONE, 32'h0, 1'b1);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] expv);
        issue(1'b0, 1'b1, f3, addr, 32'h0, K_READ, expv, 1'b1);
    endtask

    task automatic bad(input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [1:0] cause);
        issue(wr, rd, f3, addr, 32'hFFFF_FFFF, K_FAULT, {30'h0, cause}, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    // Monitors: every output pulse must match the head of its queue, in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (if1.rd_valid === 1'b1) begin
            nvec++;
            if (q1r.size() == 0) begin
                nbad++;
                $display("FAIL l1_read unexpected pulse data=%h cyc=%0d required no pulse", if1.read_data, cyc);
            end else begin
                e = q1r.pop_front();
                if (if1.read_data !== e.v || cyc != e.due) begin
                    nbad++;
                    $display("FAIL l1_read data=%h cyc=%0d required data=%h cyc=%0d", if1.read_data, cyc, e.v, e.due);
                end
            end
        end
        if (if1.fault === 1'b1) begin
            nvec++;
            if (q1f.size() == 0) begin
                nbad++;
                $display("FAIL l1_fault unexpected pulse cause=%0d cyc=%0d required no pulse", if1.fault_cause, cyc);
            end else begin
                e = q1f.pop_front();
                if (if1.fault_cause !== e.v[1:0] || cyc != e.due) begin
                    nbad++;
                    $display("FAIL l1_fault cause=%0d cyc=%0d required cause=%0d cyc=%0d", if1.fault_cause, cyc, e.v[1:0], e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if3.rd_valid === 1'b1) begin
            nvec++;
            if (q3r.size() == 0) begin
                nbad++;
                $display("FAIL l3_read unexpected pulse data=%h cyc=%0d required no pulse", if3.read_data, cyc);
            end else begin
                e = q3r.pop_front();
                if (if3.read_data !== e.v || cyc != e.due) begin
                    nbad++;
                    $display("FAIL l3_read data=%h cyc=%0d required data=%h cyc=%0d", if3.read_data, cyc, e.v, e.due);
                end
            end
        end
        if (if3.fault === 1'b1) begin
            nvec++;
            if (q3f.size() == 0) begin
                nbad++;
                $display("FAIL l3_fault unexpected pulse cause=%0d cyc=%0d required no pulse", if3.fault_cause, cyc);
            end else begin
                e = q3f.pop_front();
                if (if3.fault_cause !== e.v[1:0] || cyc != e.due) begin
                    nbad++;
                    $display("FAIL l3_fault cause=%0d cyc=%0d required cause=%0d cyc=%0d", if3.fault_cause, cyc, e.v[1:0], e.due);
                end
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l1_read_data", if1.read_data, 32'h0);
        chk("rst_l1_rd_valid", {31'h0, if1.rd_valid}, 32'h0);
        chk("rst_l1_fault", {31'h0, if1.fault}, 32'h0);
        chk("rst_l1_fault_cause", {30'h0, if1.fault_cause}, 32'h0);
        chk("rst_l3_read_data", if3.read_data, 32'h0);
        chk("rst_l3_rd_valid", {31'h0, if3.rd_valid}, 32'h0);
        chk("rst_l3_fault", {31'h0, if3.fault}, 32'h0);
        chk("rst_l3_fault_cause", {30'h0, if3.fault_cause}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word store / load round trip.
        st(F_W, 32'h10, 32'h8000_00FF);
        ld(F_W, 32'h10, 32'h8000_00FF);

        // Byte store into lane 3, then narrow loads with both extensions.
        st(F_B, 32'h13, 32'h1234_56AB);
        ld(F_B,  32'h13, 32'hFFFF_FFAB);
        ld(F_BU, 32'h13, 32'h0000_00AB);
        ld(F_W,  32'h10, 32'hAB00_00FF);
        ld(F_H,  32'h12, 32'hFFFF_AB00);
        ld(F_HU, 32'h12, 32'h0000_AB00);
        st(F_H, 32'h10, 32'hDEAD_5555);
        ld(F_W, 32'h10, 32'hAB00_5555);

        // Faults: misaligned, out of range (no write), priority ordering.
        bad(1'b0, 1'b1, F_H, 32'h11, 2'b01);
        st(F_W, 32'h0, 32'h1111_1111);
        st(F_W, 32'h4, 32'h2222_2222);
        st(F_W, 32'h8, 32'h3333_3333);
        st(F_W, 32'hC, 32'h4444_4444);
        bad(1'b1, 1'b0, F_W, 32'h200, 2'b10);
        bad(1'b0, 1'b1, F_W, 32'h201, 2'b01);
        bad(1'b0, 1'b1, 3'b110, 32'h203, 2'b11);

        // Back-to-back loads: word 0 must be unaffected by the rejected store to 0x200.
        ld(F_W, 32'h0, 32'h1111_1111);
        ld(F_W, 32'h4, 32'h2222_2222);
        ld(F_W, 32'h8, 32'h3333_3333);
        ld(F_W, 32'hC, 32'h4444_4444);

        // Store wins over a simultaneous load: no pulse, no fault.
        issue(1'b1, 1'b1, F_W, 32'h20, 32'h1234_5678, K_NONE, 32'h0, 1'b1);
        ld(F_W, 32'h20, 32'h1234_5678);

        // Illegal funct3 on load and store, back to back; the store must not write.
        bad(1'b0, 1'b1, 3'b011, 32'h20, 2'b11);
        bad(1'b1, 1'b0, F_BU, 32'h20, 2'b11);
        ld(F_W, 32'h20, 32'h1234_5678);
        repeat (5) @(posedge clk);
        #1;

        // Reset after two loads are accepted: latency-1 copy has already delivered them,
        // latency-3 copy must squash both; requests during reset are ignored.
        issue(1'b0, 1'b1, F_W, 32'h0, 32'h0, K_READ, 32'h1111_1111, 1'b0);
        issue(1'b0, 1'b1, F_W, 32'h4, 32'h0, K_READ, 32'h2222_2222, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, F_W, 32'h8, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, F_W, 32'hC, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_l1_read_data", if1.read_data, 32'h0);
        chk("post_rst_l3_read_data", if3.read_data, 32'h0);
        chk("post_rst_l1_fault_cause", {30'h0, if1.fault_cause}, 32'h0);
        chk("post_rst_l3_fault_cause", {30'h0, if3.fault_cause}, 32'h0);
        @(posedge clk); #1;

        // Memory survives reset; the store presented during reset was ignored.
        ld(F_W, 32'h10, 32'hAB00_5555);
        ld(F_W, 32'hC, 32'h4444_4444);
        bad(1'b1, 1'b0, 3'b111, 32'h0, 2'b11);

        for (int i = 0; i < 20 && (q1r.size() + q1f.size() + q3r.size() + q3f.size()) != 0; i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_l1_read", q1r.size(), 32'h0);
        chk("drain_l1_fault", q1f.size(), 32'h0);
        chk("drain_l3_read", q3r.size(), 32'h0);
        chk("drain_l3_fault", q3f.size(), 32'h0);
        chk("held_l1_fault_cause", {30'h0, if1.fault_cause}, 32'h3);
        chk("held_l3_fault_cause", {30'h0, if3.fault_cause}, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
